// File: rtl/param_counter_pkg.sv
// Shared constants and helpers for the parameterised counter.
// No logic; imported by the counter and its prescaler.
package param_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Bits needed to hold 0..prescale-1; never less than one bit.
  function automatic int ps_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/param_counter_if.sv
// Control and status bundle of param_counter; the counter drives status, the user drives control.
// Plain wires, no flow control: every control input is sampled on each rising clock edge.
interface param_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up_down;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] counter_out;
  logic             terminal;
  logic             overflow;

  modport master (
    output enable, up_down, clear, load, load_value,
    input  counter_out, terminal, overflow
  );

  modport slave (
    input  enable, up_down, clear, load, load_value,
    output counter_out, terminal, overflow
  );
endinterface

// File: rtl/counter_prescaler.sv
// Emits one step per PRESCALE enabled cycles; step is combinational from enable and the phase register.
// No backpressure; restart forces the phase back to zero on the next edge.
module counter_prescaler
  import param_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic step
);

  generate
    if (PRESCALE == 1) begin : g_pass
      logic unused_ok;
      assign unused_ok = &{1'b0, clock, reset, restart};
      assign step      = enable;
    end else begin : g_div
      localparam int PW = ps_width(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          phase <= '0;
        end else if (restart) begin
          phase <= '0;
        end else if (enable) begin
          phase <= (phase == LAST) ? '0 : phase + 1'b1;
        end
      end

      assign step = enable && (phase == LAST);
    end
  endgenerate

endmodule

// File: rtl/param_counter.sv
// Up/down modulo counter with load/clear, wrap or saturate, prescaled steps; outputs registered, one-edge latency.
// No backpressure; priority per edge is reset > clear > load > step.
module param_counter
  import param_counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int              SATURATE = MODE_WRAP,
  parameter int              PRESCALE = 1
) (
  input logic            clock,
  input logic            reset,
  param_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_step;
  logic [WIDTH-1:0] load_clamped;
  logic             step;
  logic             restart;
  logic             at_edge;
  logic             boundary;
  logic             terminal_q;
  logic             overflow_q;

  assign restart = bus.clear | bus.load;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .enable  (bus.enable),
    .restart (restart),
    .step    (step)
  );

  // The boundary depends on direction, so a direction change only matters at the next step.
  always_comb begin
    at_edge      = bus.up_down ? (count == MAX) : (count == '0);
    boundary     = step && at_edge;
    count_step   = count;
    if (!at_edge) begin
      count_step = bus.up_down ? count + 1'b1 : count - 1'b1;
    end else if (SATURATE != MODE_SAT) begin
      count_step = bus.up_down ? '0 : MAX;
    end
    load_clamped = (bus.load_value > MAX) ? MAX : bus.load_value;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      terminal_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      count      <= '0;
      terminal_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.load) begin
      count      <= load_clamped;
      terminal_q <= 1'b0;
    end else if (step) begin
      count      <= count_step;
      terminal_q <= boundary;
      if (boundary) begin
        overflow_q <= 1'b1;
      end
    end else begin
      terminal_q <= 1'b0;
    end
  end

  assign bus.counter_out = count;
  assign bus.terminal    = terminal_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_param_counter.sv
// Drives four differently parameterised counters with shared stimulus and checks each against
// a cycle-level arithmetic model of the counting rules.
module tb_param_counter;

  localparam int NDUT = 4;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       clear;
  logic       load;
  logic [3:0] load_value;

  int n_chk  = 0;
  int n_fail = 0;

  // Model configuration and state, one entry per DUT.
  int m_mod [NDUT] = '{16, 10, 10, 12};
  int m_sat [NDUT] = '{0, 1, 0, 0};
  int m_pre [NDUT] = '{1, 1, 1, 3};
  int m_cnt [NDUT];
  int m_ps  [NDUT];
  int m_term[NDUT];
  int m_ov  [NDUT];

  logic [3:0] obs_cnt [NDUT];
  logic       obs_term[NDUT];
  logic       obs_ov  [NDUT];

  param_counter_if #(.WIDTH(4)) ia ();
  param_counter_if #(.WIDTH(4)) ib ();
  param_counter_if #(.WIDTH(4)) ic ();
  param_counter_if #(.WIDTH(4)) id ();

  assign {ia.enable, ia.up_down, ia.clear, ia.load, ia.load_value} = {enable, up_down, clear, load, load_value};
  assign {ib.enable, ib.up_down, ib.clear, ib.load, ib.load_value} = {enable, up_down, clear, load, load_value};
  assign {ic.enable, ic.up_down, ic.clear, ic.load, ic.load_value} = {enable, up_down, clear, load, load_value};
  assign {id.enable, id.up_down, id.clear, id.load, id.load_value} = {enable, up_down, clear, load, load_value};

  assign obs_cnt[0] = ia.counter_out;  assign obs_term[0] = ia.terminal;  assign obs_ov[0] = ia.overflow;
  assign obs_cnt[1] = ib.counter_out;  assign obs_term[1] = ib.terminal;  assign obs_ov[1] = ib.overflow;
  assign obs_cnt[2] = ic.counter_out;  assign obs_term[2] = ic.terminal;  assign obs_ov[2] = ic.overflow;
  assign obs_cnt[3] = id.counter_out;  assign obs_term[3] = id.terminal;  assign obs_ov[3] = id.overflow;

  param_counter dut_a (.clock(clock), .reset(reset), .bus(ia));
  param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_b (.clock(clock), .reset(reset), .bus(ib));
  param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_c (.clock(clock), .reset(reset), .bus(ic));
  param_counter #(.WIDTH(4), .MODULUS(12), .PRESCALE(3)) dut_d (.clock(clock), .reset(reset), .bus(id));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_cnt[i] = 0; m_ps[i] = 0; m_term[i] = 0; m_ov[i] = 0;
    end
  endtask

  // Next-state of every model from the inputs about to be sampled.
  task automatic model_edge(input bit en, input bit ud, input bit clr, input bit ld, input int lv);
    for (int i = 0; i < NDUT; i++) begin
      bit stp;
      m_term[i] = 0;
      if (clr) begin
        m_cnt[i] = 0; m_ps[i] = 0; m_ov[i] = 0;
      end else if (ld) begin
        m_cnt[i] = (lv > m_mod[i] - 1) ? m_mod[i] - 1 : lv;
        m_ps[i]  = 0;
      end else if (en) begin
        m_ps[i] = (m_ps[i] + 1) % m_pre[i];
        stp     = (m_ps[i] == 0);
        if (stp) begin
          if ((ud && m_cnt[i] == m_mod[i] - 1) || (!ud && m_cnt[i] == 0)) begin
            m_term[i] = 1;
            m_ov[i]   = 1;
            if (!m_sat[i]) m_cnt[i] = ud ? 0 : m_mod[i] - 1;
          end else begin
            m_cnt[i] = ud ? m_cnt[i] + 1 : m_cnt[i] - 1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input int cyc);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("cyc%0d dut%0d count", cyc, i), 32'(obs_cnt[i]), 32'(m_cnt[i]));
      chk($sformatf("cyc%0d dut%0d terminal", cyc, i), 32'(obs_term[i]), 32'(m_term[i]));
      chk($sformatf("cyc%0d dut%0d overflow", cyc, i), 32'(obs_ov[i]), 32'(m_ov[i]));
    end
  endtask

  int cyc = 0;

  task automatic tick(input bit en, input bit ud, input bit clr, input bit ld, input int lv);
    enable = en; up_down = ud; clear = clr; load = ld; load_value = 4'(lv);
    model_edge(en, ud, clr, ld, lv);
    @(posedge clock);
    @(negedge clock);
    cyc++;
    check_all(cyc);
  endtask

  initial begin
    bit ud_r;
    reset = 1'b1; enable = 0; up_down = 1; clear = 0; load = 0; load_value = '0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_all(0);
    reset = 1'b0;

    // Free run upward from reset.
    for (int k = 0; k < 20; k++) tick(1, 1, 0, 0, 0);
    chk("a_after20", 32'(obs_cnt[0]), 32'd4);
    chk("a_overflow", 32'(obs_ov[0]), 32'd1);
    chk("b_saturated", 32'(obs_cnt[1]), 32'd9);
    chk("d_prescaled", 32'(obs_cnt[3]), 32'd6);

    tick(0, 1, 1, 0, 0);
    chk("b_clear_ov", 32'(obs_ov[1]), 32'd0);

    // Down from zero wraps to MODULUS-1.
    tick(1, 0, 0, 0, 0);
    chk("c_down_wrap", 32'(obs_cnt[2]), 32'd9);
    chk("c_down_term", 32'(obs_term[2]), 32'd1);

    // Load clamping and boundary suppression by load.
    tick(0, 1, 1, 0, 0);
    tick(0, 1, 0, 1, 13);
    chk("c_load_clamp", 32'(obs_cnt[2]), 32'd9);
    tick(1, 1, 0, 0, 0);
    chk("c_wrap_zero", 32'(obs_cnt[2]), 32'd0);
    chk("c_wrap_term", 32'(obs_term[2]), 32'd1);
    tick(0, 1, 0, 1, 15);
    tick(1, 1, 0, 1, 15);
    chk("c_load_suppress", 32'(obs_term[2]), 32'd0);

    // Prescaler bursts.
    tick(0, 1, 1, 0, 0);
    for (int k = 0; k < 9; k++) tick(1, 1, 0, 0, 0);
    chk("d_burst1", 32'(obs_cnt[3]), 32'd3);
    for (int k = 0; k < 2; k++) tick(0, 1, 0, 0, 0);
    chk("d_hold", 32'(obs_cnt[3]), 32'd3);
    for (int k = 0; k < 3; k++) tick(1, 1, 0, 0, 0);
    chk("d_burst2", 32'(obs_cnt[3]), 32'd4);

    // Asynchronous reset between edges.
    tick(0, 1, 1, 0, 0);
    for (int k = 0; k < 7; k++) tick(1, 1, 0, 0, 0);
    chk("a_at7", 32'(obs_cnt[0]), 32'd7);
    enable = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_count", 32'(obs_cnt[0]), 32'd0);
    chk("async_rst_term", 32'(obs_term[0]), 32'd0);
    chk("async_rst_ov", 32'(obs_ov[0]), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    check_all(cyc);
    for (int k = 0; k < 4; k++) tick(1, 1, 0, 0, 0);
    chk("a_resume", 32'(obs_cnt[0]), 32'd4);

    // Randomised traffic.
    ud_r = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) ud_r = ~ud_r;
      tick($urandom_range(0, 3) != 0, ud_r, $urandom_range(0, 23) == 0,
           $urandom_range(0, 11) == 0, int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/param_counter.md
# param_counter

Parametrised successor to the team's 4-bit enable counter. It adds generic width and modulus, up/down direction, synchronous load and clear, wrap or saturate mode, and an enable prescaler, and it reports boundary events through a terminal pulse and a sticky overflow flag. It sits wherever a free-running or gated event/tick counter is needed, and drops in for the old counter when all parameters are left at their defaults and only the original control inputs are used.

## Interface
Parameters:
- WIDTH, 4: counter width in bits; legal range 1 to 32.
- MODULUS, 2**WIDTH: count range is 0 to MODULUS-1; legal range 2 to 2**WIDTH.
- SATURATE, 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.
- PRESCALE, 1: number of enabled cycles per count step; legal range 1 to 2**16.

Ports (one clock; reset is asynchronous and active-high):
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: qualifies counting and prescaler advance.
- up_down, in, 1: 1 = count up, 0 = count down.
- clear, in, 1: synchronous clear.
- load, in, 1: synchronous load.
- load_value, in, WIDTH: value written on load.
- counter_out, out, WIDTH: current count.
- terminal, out, 1: one-cycle boundary-event pulse.
- overflow, out, 1: sticky boundary-event flag.

## Operation
- Reset values: counter_out = 0, terminal = 0, overflow = 0, prescaler = 0.
- Per-edge priority: reset > clear > load > step.
- clear sets counter_out = 0, prescaler = 0 and overflow = 0.
- load sets counter_out = min(load_value, MODULUS-1) and prescaler = 0. overflow is unchanged.
- Prescaler advances only when enable = 1:
  - On each enabled cycle it counts 0 to PRESCALE-1.
  - It wraps to 0 at PRESCALE-1.
  - step = enable && (prescaler == PRESCALE-1).
  - With PRESCALE = 1, step = enable.
- The prescaler holds its value while enable = 0.
- Step, counting up:
  - Below MODULUS-1: counter_out is incremented.
  - At MODULUS-1 with wrap: counter_out becomes 0 (boundary event).
  - At MODULUS-1 with saturate: counter_out holds (boundary event).
- Step, counting down:
  - Above 0: counter_out is decremented.
  - At 0 with wrap: counter_out becomes MODULUS-1 (boundary event).
  - At 0 with saturate: counter_out holds (boundary event).
- On a boundary event, terminal = 1 for exactly one cycle and overflow is set.
  - In saturate mode, every further blocked step re-pulses terminal.
- Arithmetic is modulo MODULUS, never modulo 2**WIDTH. counter_out never leaves 0 to MODULUS-1.
- A change on up_down takes effect on the next step. No state is flushed.

## Timing
- All outputs are registered.
- counter_out updates on the rising edge at which step, load or clear is sampled.
- terminal is high during the cycle right after the boundary edge, aligned with the post-wrap or held counter_out.
- clear or load in the same cycle as a boundary step suppresses the event: no terminal pulse and no overflow set.
- Reset asserted mid-count:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - The first step after release requires PRESCALE enabled edges.
- An enable pulse of a single cycle advances the prescaler by exactly 1.

## Structure
- Shared package param_counter_pkg holds:
  - The SATURATE mode constants: MODE_WRAP = 0 and MODE_SAT = 1.
  - A clog2-based prescaler width function.
- One sub-module, counter_prescaler:
  - Inputs: clock, reset, enable, restart (restart = clear | load).
  - Output: step.
  - When PRESCALE = 1 it reduces to a pass-through.
- The top level holds the count register, the boundary logic and the flags.

## Test plan
- Defaults (WIDTH=4, modulus 16, wrap, PRESCALE=1), reset pulse then enable high for 20 cycles:
  - counter_out runs 0 to 15, then 0 to 3.
  - terminal pulses once, in the cycle counter_out = 0 after 15.
  - overflow is 1 afterwards.
- MODULUS=10, SATURATE=1, count up 12 steps:
  - counter_out holds at 9.
  - terminal pulses on each of the last 3 steps.
  - clear then gives counter_out = 0 and overflow = 0.
- Wrap mode, up_down=0 from 0, one step:
  - counter_out = MODULUS-1, terminal pulses once.
  - With MODULUS=10, counter_out = 9.
- MODULUS=10, load with load_value=13 then count up:
  - Load gives counter_out = 9.
  - The next step wraps to 0 with a terminal pulse.
  - load coincident with a boundary step gives no terminal pulse.
- PRESCALE=3, enable high for 9 cycles then low for 2, then high for 3:
  - counter_out = 3 after the first burst.
  - It holds during the low cycles.
  - It reaches 4 after the third re-enabled cycle.
- Reset asserted between clock edges at count 7:
  - counter_out = 0 and the flags = 0 before the next edge.
  - Counting resumes from 0 after reset is released.
